// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the parallel-ADC device emulator.
// Holds the FSM encoding and the counter-width helper used by the top level.
package adc_emu_pkg;

    localparam int ADDR_W     = 4;
    localparam int DEF_DATA_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_CONV = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width of the shared down-counter; at least 1 bit even when both phases are single-cycle.
    function automatic int cnt_width(input int acq, input int conv);
        int m;
        m = (acq > conv) ? acq : conv;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/adc_emu_if.sv
// Device-side bus of the emulated ADC: conversion handshake plus value-bank configuration.
// Handshake: ADC_CONVST is sampled on CLK in IDLE; ADC_STS=1 means busy, ADC_DATA is valid whenever ADC_STS=0.
interface adc_emu_if #(
    parameter int DATA_W = adc_emu_pkg::DEF_DATA_W
);
    import adc_emu_pkg::*;

    logic              ADC_CONVST;
    logic [ADDR_W-1:0] ADC_ADDR;
    logic              ADC_STS;
    logic [DATA_W-1:0] ADC_DATA;
    logic              CFG_WE;
    logic [ADDR_W-1:0] CFG_CH;
    logic [DATA_W-1:0] CFG_DATA;
    logic              CFG_RAMP;
    logic              OVERRUN;

    modport master (
        output ADC_CONVST, ADC_ADDR, CFG_WE, CFG_CH, CFG_DATA, CFG_RAMP,
        input  ADC_STS, ADC_DATA, OVERRUN
    );

    modport slave (
        input  ADC_CONVST, ADC_ADDR, CFG_WE, CFG_CH, CFG_DATA, CFG_RAMP,
        output ADC_STS, ADC_DATA, OVERRUN
    );

endinterface

// File: rtl/adc_emu_sample_bank.sv
// Per-channel sample value bank: one write port, one ramp-increment port, one async read port.
// A configuration write beats a ramp update aimed at the same channel in the same cycle.
module adc_emu_sample_bank
    import adc_emu_pkg::*;
#(
    parameter int CHANNELS  = 16,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RAMP_STEP = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wch,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_ramp,
    input  logic [ADDR_W-1:0] i_ramp_ch,
    input  logic [ADDR_W-1:0] i_rd_ch,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int NUM_SLOTS = 2 ** ADDR_W;

    // Slots at or above CHANNELS are never written, so they stay at zero and reads there return 0.
    logic [DATA_W-1:0] r_bank [NUM_SLOTS];
    logic              w_rd_in_range;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (i_we && (i_wch == ADDR_W'(i))) begin
                    r_bank[i] <= i_wdata;
                end else if (i_ramp && (i_ramp_ch == ADDR_W'(i))) begin
                    r_bank[i] <= r_bank[i] + DATA_W'(RAMP_STEP);
                end
            end
        end
    end

    assign w_rd_in_range = ({1'b0, i_rd_ch} < (ADDR_W + 1)'(CHANNELS));
    assign o_rdata       = w_rd_in_range ? r_bank[i_rd_ch] : '0;

endmodule

// File: rtl/adc_device_emulator.sv
// Emulated parallel ADC: accepts CONVST, stays busy for ACQ+CONV+1 cycles, then presents the bank sample.
// FSM, shared down-counter, address latch and output registers live here; values live in the sample bank.
module adc_device_emulator
    import adc_emu_pkg::*;
#(
    parameter int CHANNELS    = 16,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACQ_CYCLES  = 2,
    parameter int CONV_CYCLES = 300,
    parameter int RAMP_STEP   = 1
) (
    input  logic       CLK,
    input  logic       RST,
    adc_emu_if.slave   bus,
    output logic [1:0] o_dbg_state
);

    localparam int CNT_W = cnt_width(ACQ_CYCLES, CONV_CYCLES);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_sts;
    logic [DATA_W-1:0] r_data;
    logic              r_overrun;

    logic              w_accept;
    logic              w_load_conv;
    logic              w_done;
    logic              w_ramp;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_load_conv = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.ADC_CONVST) begin
                    w_accept = 1'b1;
                    w_next   = ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (r_cnt == '0) begin
                    w_load_conv = 1'b1;
                    w_next      = ST_CONV;
                end
            end
            ST_CONV: begin
                if (r_cnt == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Counter is loaded with N-1 on phase entry, so each phase lasts exactly N cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_sts     <= 1'b0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= bus.ADC_CONVST && (r_state != ST_IDLE);
            if (w_accept) begin
                r_addr <= bus.ADC_ADDR;
                r_sts  <= 1'b1;
                r_cnt  <= CNT_W'(ACQ_CYCLES - 1);
            end else if (w_load_conv) begin
                r_cnt <= CNT_W'(CONV_CYCLES - 1);
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_done) begin
                r_data <= w_rdata;
                r_sts  <= 1'b0;
            end
        end
    end

    assign w_ramp = w_done && bus.CFG_RAMP;

    adc_emu_sample_bank #(
        .CHANNELS  (CHANNELS),
        .DATA_W    (DATA_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_bank (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_we      (bus.CFG_WE),
        .i_wch     (bus.CFG_CH),
        .i_wdata   (bus.CFG_DATA),
        .i_ramp    (w_ramp),
        .i_ramp_ch (r_addr),
        .i_rd_ch   (r_addr),
        .o_rdata   (w_rdata)
    );

    assign bus.ADC_STS  = r_sts;
    assign bus.ADC_DATA = r_data;
    assign bus.OVERRUN  = r_overrun;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_adc_device_emulator.sv
// Self-checking bench for adc_device_emulator: table of conversions plus reset corner sequences.
// Expected samples are queued when a conversion is started and compared when ADC_STS falls.
module tb_adc_device_emulator;

    localparam int CHANNELS = 12;
    localparam int DATA_W   = 12;
    localparam int ACQ      = 2;
    localparam int CONV     = 300;
    localparam int BUSY     = ACQ + CONV + 1;
    localparam int NV       = 14;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    adc_emu_if #(.DATA_W(DATA_W)) bus();

    adc_device_emulator #(
        .CHANNELS    (CHANNELS),
        .DATA_W      (DATA_W),
        .ACQ_CYCLES  (ACQ),
        .CONV_CYCLES (CONV),
        .RAMP_STEP   (1)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          wr;
        logic [3:0]  ch;
        logic [11:0] val;
        bit          ramp;
        int          ov_at;
        bit          late_we;
        logic [11:0] late_val;
        logic [11:0] exp;
    } vec_t;

    vec_t        vecs [NV];
    logic [11:0] exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [3:0] ch, input logic [11:0] val);
        bus.CFG_WE   = 1'b1;
        bus.CFG_CH   = ch;
        bus.CFG_DATA = val;
        tick();
        bus.CFG_WE   = 1'b0;
    endtask

    // One conversion: optional preload, optional overrun pulse and optional write in the DONE cycle.
    task automatic run_row(input vec_t v, input int idx);
        int          busy;
        bit          held;
        logic [11:0] data_before;
        logic [11:0] got_exp;
        if (v.wr) cfg_write(v.ch, v.val);
        bus.CFG_RAMP   = v.ramp;
        bus.ADC_ADDR   = v.ch;
        bus.ADC_CONVST = 1'b1;
        exp_q.push_back(v.exp);
        data_before = bus.ADC_DATA;
        tick();
        busy = 0;
        held = 1'b1;
        while (bus.ADC_STS === 1'b1 && busy < 1000) begin
            if (v.ov_at != 0 && busy == v.ov_at) begin
                bus.ADC_CONVST = 1'b1;
                bus.ADC_ADDR   = 4'd7;
            end else begin
                bus.ADC_CONVST = 1'b0;
            end
            bus.CFG_WE   = v.late_we && (busy == BUSY - 1);
            bus.CFG_CH   = v.ch;
            bus.CFG_DATA = v.late_val;
            if (bus.ADC_DATA !== data_before) held = 1'b0;
            tick();
            busy++;
            if (v.ov_at != 0 && busy == v.ov_at + 1) check($sformatf("row%0d_overrun_hi", idx), 32'(bus.OVERRUN), 32'd1);
            if (v.ov_at != 0 && busy == v.ov_at + 2) check($sformatf("row%0d_overrun_lo", idx), 32'(bus.OVERRUN), 32'd0);
        end
        bus.CFG_WE = 1'b0;
        check($sformatf("row%0d_busy_cycles", idx), 32'(busy), 32'(BUSY));
        check($sformatf("row%0d_data_held", idx), 32'(held), 32'd1);
        if (exp_q.size() == 0) begin
            check($sformatf("row%0d_queue_empty", idx), 32'd0, 32'd1);
        end else begin
            got_exp = exp_q.pop_front();
            check($sformatf("row%0d_data", idx), 32'(bus.ADC_DATA), 32'(got_exp));
        end
        check($sformatf("row%0d_state_idle", idx), 32'(dbg_state), 32'd0);
    endtask

    initial begin
        //              wr  ch     val      ramp ov  late  late_val exp
        vecs[0]  = '{1'b1, 4'd2,  12'h005, 1'b0, 0,  1'b0, 12'h000, 12'h005};
        vecs[1]  = '{1'b0, 4'd2,  12'h000, 1'b1, 0,  1'b0, 12'h000, 12'h005};
        vecs[2]  = '{1'b0, 4'd2,  12'h000, 1'b0, 0,  1'b0, 12'h000, 12'h006};
        vecs[3]  = '{1'b1, 4'd2,  12'h0AA, 1'b0, 10, 1'b0, 12'h000, 12'h0AA};
        vecs[4]  = '{1'b0, 4'd7,  12'h000, 1'b0, 0,  1'b0, 12'h000, 12'h000};
        vecs[5]  = '{1'b1, 4'd5,  12'hFFE, 1'b1, 0,  1'b0, 12'h000, 12'hFFE};
        vecs[6]  = '{1'b0, 4'd5,  12'h000, 1'b1, 0,  1'b0, 12'h000, 12'hFFF};
        vecs[7]  = '{1'b0, 4'd5,  12'h000, 1'b1, 0,  1'b0, 12'h000, 12'h000};
        vecs[8]  = '{1'b0, 4'd5,  12'h000, 1'b1, 0,  1'b1, 12'h123, 12'h001};
        vecs[9]  = '{1'b0, 4'd5,  12'h000, 1'b0, 0,  1'b0, 12'h000, 12'h123};
        vecs[10] = '{1'b1, 4'd13, 12'hABC, 1'b0, 0,  1'b0, 12'h000, 12'h000};
        vecs[11] = '{1'b1, 4'd11, 12'h7A5, 1'b0, 0,  1'b0, 12'h000, 12'h7A5};
        vecs[12] = '{1'b0, 4'd0,  12'h000, 1'b1, 0,  1'b0, 12'h000, 12'h000};
        vecs[13] = '{1'b0, 4'd0,  12'h000, 1'b0, 0,  1'b0, 12'h000, 12'h001};

        bus.ADC_CONVST = 1'b1;
        bus.ADC_ADDR   = 4'd3;
        bus.CFG_WE     = 1'b0;
        bus.CFG_CH     = 4'd0;
        bus.CFG_DATA   = 12'h000;
        bus.CFG_RAMP   = 1'b0;
        rst            = 1'b1;

        // Reset with CONVST asserted: nothing may start.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset%0d_sts", i), 32'(bus.ADC_STS), 32'd0);
            check($sformatf("reset%0d_data", i), 32'(bus.ADC_DATA), 32'd0);
            check($sformatf("reset%0d_overrun", i), 32'(bus.OVERRUN), 32'd0);
            check($sformatf("reset%0d_state", i), 32'(dbg_state), 32'd0);
        end
        bus.ADC_CONVST = 1'b0;
        rst            = 1'b0;
        tick();
        check("post_reset_sts", 32'(bus.ADC_STS), 32'd0);

        for (int i = 0; i < NV; i++) begin
            run_row(vecs[i], i);
        end

        // Reset in the middle of a conversion, then a fresh full-length conversion.
        cfg_write(4'd11, 12'h7A5);
        bus.ADC_ADDR   = 4'd11;
        bus.ADC_CONVST = 1'b1;
        tick();
        bus.ADC_CONVST = 1'b0;
        for (int i = 0; i < ACQ + 100; i++) tick();
        check("midconv_busy", 32'(bus.ADC_STS), 32'd1);
        rst = 1'b1;
        tick();
        check("midrst_sts", 32'(bus.ADC_STS), 32'd0);
        check("midrst_data", 32'(bus.ADC_DATA), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        tick();
        run_row('{1'b0, 4'd11, 12'h000, 1'b0, 0, 1'b0, 12'h000, 12'h000}, 100);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
